// File: rtl/posit_extract_es3_if.sv
// Stream interface for the ES=3 posit decoder: posit words in, unpacked value fields out.
interface posit_extract_es3_if #(
  parameter int TAGW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_posit;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic            out_sign;
  logic [8:0]      out_scale;
  logic [2:0]      out_exponent;
  logic [25:0]     out_fraction;
  logic            out_inf;
  logic            out_zero;
  logic [TAGW-1:0] out_tag;

  modport master (
    output in_valid, in_posit, in_tag, out_ready,
    input  in_ready, out_valid, out_sign, out_scale, out_exponent,
           out_fraction, out_inf, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_posit, in_tag, out_ready,
    output in_ready, out_valid, out_sign, out_scale, out_exponent,
           out_fraction, out_inf, out_zero, out_tag
  );
endinterface

// File: rtl/posit_extract_es3.sv
// Three-stage pipelined ES=3 posit decoder: sign/abs, regime run-length, exponent/fraction split.
// Each stage refills whenever it is empty or its successor is taking its contents.
module posit_extract_es3 #(
  parameter int NBITS = 32,
  parameter int ES    = 3,
  parameter int TAGW  = 8
) (
  input  logic               clk,
  input  logic               reset,
  posit_extract_es3_if.slave bus
);
  localparam int FW = NBITS - 3 - ES;  // fraction width
  localparam int RW = NBITS - 3;       // bits left after sign and the shortest regime

  logic             w_ready1, w_ready2, w_ready3;
  logic [NBITS-2:0] w_abs;
  logic [NBITS-3:0] w_diff;
  logic [4:0]       w_run;
  logic [5:0]       w_k;
  logic [RW-1:0]    w_rem;
  logic             w_special;

  logic             r_s1_valid, r_s1_sign, r_s1_zero, r_s1_inf;
  logic [NBITS-2:0] r_s1_abs;
  logic [TAGW-1:0]  r_s1_tag;

  logic             r_s2_valid, r_s2_sign, r_s2_zero, r_s2_inf;
  logic [5:0]       r_s2_k;
  logic [RW-1:0]    r_s2_rem;
  logic [TAGW-1:0]  r_s2_tag;

  logic             r_s3_valid, r_s3_sign, r_s3_zero, r_s3_inf;
  logic [8:0]       r_s3_scale;
  logic [ES-1:0]    r_s3_exp;
  logic [FW-1:0]    r_s3_frac;
  logic [TAGW-1:0]  r_s3_tag;

  assign w_ready3 = !r_s3_valid || bus.out_ready;
  assign w_ready2 = !r_s2_valid || w_ready3;
  assign w_ready1 = !r_s1_valid || w_ready2;

  // Only the low bits of the magnitude are kept; bit 31 of |x| is set only for NaR.
  assign w_abs = bus.in_posit[NBITS-1] ? (~bus.in_posit[NBITS-2:0] + (NBITS-1)'(1))
                                       : bus.in_posit[NBITS-2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_abs   <= '0;
      r_s1_tag   <= '0;
    end else if (w_ready1) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_sign <= bus.in_posit[NBITS-1];
        r_s1_zero <= (bus.in_posit == '0);
        r_s1_inf  <= (bus.in_posit == {1'b1, {(NBITS-1){1'b0}}});
        r_s1_abs  <= w_abs;
        r_s1_tag  <= bus.in_tag;
      end
    end
  end

  // A set bit in w_diff marks where the regime run (starting at bit 30) ends.
  genvar gi;
  generate
    for (gi = 0; gi < NBITS - 2; gi++) begin : g_diff
      assign w_diff[gi] = r_s1_abs[gi] ^ r_s1_abs[NBITS-2];
    end
  endgenerate

  always_comb begin
    w_run = 5'(NBITS - 1);
    for (int i = 0; i < NBITS - 2; i++) begin
      if (w_diff[i]) w_run = 5'(NBITS - 2 - i);
    end
  end

  assign w_k   = r_s1_abs[NBITS-2] ? ({1'b0, w_run} - 6'd1) : (6'd0 - {1'b0, w_run});
  assign w_rem = r_s1_abs[RW-1:0] << (w_run - 5'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_zero  <= 1'b0;
      r_s2_inf   <= 1'b0;
      r_s2_k     <= '0;
      r_s2_rem   <= '0;
      r_s2_tag   <= '0;
    end else if (w_ready2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sign <= r_s1_sign;
        r_s2_zero <= r_s1_zero;
        r_s2_inf  <= r_s1_inf;
        r_s2_k    <= w_k;
        r_s2_rem  <= w_rem;
        r_s2_tag  <= r_s1_tag;
      end
    end
  end

  // Zero and NaR carry meaningless regime data, so their numeric fields are forced to 0.
  assign w_special = r_s2_zero || r_s2_inf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s3_valid <= 1'b0;
      r_s3_sign  <= 1'b0;
      r_s3_zero  <= 1'b0;
      r_s3_inf   <= 1'b0;
      r_s3_scale <= '0;
      r_s3_exp   <= '0;
      r_s3_frac  <= '0;
      r_s3_tag   <= '0;
    end else if (w_ready3) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_sign  <= r_s2_sign;
        r_s3_zero  <= r_s2_zero;
        r_s3_inf   <= r_s2_inf;
        r_s3_scale <= w_special ? '0 : {r_s2_k, r_s2_rem[RW-1 -: ES]};
        r_s3_exp   <= w_special ? '0 : r_s2_rem[RW-1 -: ES];
        r_s3_frac  <= w_special ? '0 : r_s2_rem[FW-1:0];
        r_s3_tag   <= r_s2_tag;
      end
    end
  end

  assign bus.in_ready     = w_ready1;
  assign bus.out_valid    = r_s3_valid;
  assign bus.out_sign     = r_s3_sign;
  assign bus.out_scale    = r_s3_scale;
  assign bus.out_exponent = r_s3_exp;
  assign bus.out_fraction = r_s3_frac;
  assign bus.out_inf      = r_s3_inf;
  assign bus.out_zero     = r_s3_zero;
  assign bus.out_tag      = r_s3_tag;
endmodule

// File: tb/tb_posit_extract_es3.sv
// Bench for posit_extract_es3: directed decodes, streaming, backpressure, random traffic and mid-stream reset,
// all scored against a bit-walking reference decoder.
module tb_posit_extract_es3;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  posit_extract_es3_if #(.TAGW(8)) bus ();

  posit_extract_es3 #(.NBITS(32), .ES(3), .TAGW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic [63:0] exp_q[$];
  logic        hold_vld = 1'b0;
  logic [63:0] hold_val;
  logic [7:0]  dir_tag = 8'd0;

  function automatic logic [63:0] pk(input logic [7:0] t, input logic s, input logic i,
                                     input logic z, input int sc, input int ex, input int fr);
    return {15'd0, t, s, i, z, sc[8:0], ex[2:0], fr[25:0]};
  endfunction

  // Walk the magnitude bit by bit: regime run, terminator, then exponent and fraction bits.
  function automatic logic [63:0] model(input logic [31:0] p, input logic [7:0] t);
    logic [31:0] a;
    logic        s, rb;
    int          r, k, pos, ex, fr;
    if (p == 32'h0) return pk(t, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    if (p == 32'h8000_0000) return pk(t, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    s   = p[31];
    a   = s ? (32'h0 - p) : p;
    rb  = a[30];
    r   = 0;
    pos = 30;
    while (pos >= 0 && a[pos] == rb) begin
      r++;
      pos--;
    end
    k = rb ? r - 1 : -r;
    pos--;
    ex = 0;
    for (int j = 0; j < 3; j++) begin
      ex = ex * 2;
      if (pos >= 0 && a[pos]) ex = ex + 1;
      pos--;
    end
    fr = 0;
    for (int j = 0; j < 26; j++) begin
      fr = fr * 2;
      if (pos >= 0 && a[pos]) fr = fr + 1;
      pos--;
    end
    return pk(t, s, 1'b0, 1'b0, 8 * k + ex, ex, fr);
  endfunction

  function logic [63:0] observed();
    return {15'd0, bus.out_tag, bus.out_sign, bus.out_inf, bus.out_zero,
            bus.out_scale, bus.out_exponent, bus.out_fraction};
  endfunction

  function automatic logic [31:0] rand_posit();
    logic [31:0] r;
    logic [31:0] v;
    r = $urandom;
    case ($urandom_range(0, 9))
      0:       v = 32'h0;
      1:       v = 32'h8000_0000;
      2, 3:    v = (r >> $urandom_range(1, 31));
      4, 5:    v = (r >> $urandom_range(1, 31)) ^ 32'h7FFF_FFFF;
      default: v = r;
    endcase
    if ($urandom_range(0, 3) == 0) v = 32'h0 - v;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Scoreboard: words are captured as they are accepted and compared as they leave.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      hold_vld = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_posit, bus.in_tag));
      if (hold_vld) check("hold", {bus.out_valid, observed()}, {1'b1, hold_val});
      hold_vld = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          $display("out tag=%02h sign=%0d scale=%0d exp=%0d frac=%07h inf=%0d zero=%0d",
                   bus.out_tag, bus.out_sign, $signed(bus.out_scale), bus.out_exponent,
                   bus.out_fraction, bus.out_inf, bus.out_zero);
          n_out++;
          if (exp_q.size() == 0) check("spurious", 64'(exp_q.size()), 64'd1);
          else check("result", observed(), exp_q.pop_front());
        end else begin
          hold_vld = 1'b1;
          hold_val = observed();
        end
      end
    end
  end

  task automatic drive_cycle(input logic v, input logic [31:0] p, input logic [7:0] t, output logic acc);
    bus.in_valid = v;
    bus.in_posit = p;
    bus.in_tag   = t;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
  endtask

  // Latency counts the accepting edge as edge 1; the result is visible after edge 3.
  task automatic send_one(input logic [31:0] p, input logic [7:0] t, output logic [63:0] res, output int lat);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    bus.out_ready = 1'b1;
    while (!acc && n < 20) begin
      drive_cycle(1'b1, p, t, acc);
      n++;
    end
    bus.in_valid = 1'b0;
    check("accept", 64'(acc), 64'd1);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = observed();
  endtask

  task automatic run_dir(input logic [31:0] p, input logic s, input logic i, input logic z,
                         input int sc, input int ex, input int fr);
    logic [63:0] res;
    int          lat;
    dir_tag++;
    send_one(p, dir_tag, res, lat);
    check("dir_lat", 64'(lat), 64'd3);
    check("dir_val", res, pk(dir_tag, s, i, z, sc, ex, fr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc, pend, v;
    logic [31:0] p;
    logic [7:0]  tg;
    logic [63:0] snap, res;
    int          cnt, first, last, nacc, n0, w, lat;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_posit  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ovalid", 64'(bus.out_valid), 64'd0);
    check("rst_data", observed(), 64'd0);
    check("rst_iready", 64'(bus.in_ready), 64'd1);
    reset = 1'b0;

    run_dir(32'h4000_0000, 1'b0, 1'b0, 1'b0,    0, 0, 0);
    run_dir(32'h4400_0000, 1'b0, 1'b0, 1'b0,    1, 1, 0);
    run_dir(32'h4000_0001, 1'b0, 1'b0, 1'b0,    0, 0, 1);
    run_dir(32'h2000_0000, 1'b0, 1'b0, 1'b0,   -8, 0, 0);
    run_dir(32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0,  240, 0, 0);
    run_dir(32'h0000_0001, 1'b0, 1'b0, 1'b0, -240, 0, 0);
    run_dir(32'hC000_0000, 1'b1, 1'b0, 1'b0,    0, 0, 0);
    run_dir(32'h0000_0000, 1'b0, 1'b0, 1'b1,    0, 0, 0);
    run_dir(32'h8000_0000, 1'b1, 1'b1, 1'b0,    0, 0, 0);
    run_dir(32'h5A5A_5A5A, 1'b0, 1'b0, 1'b0,    6, 6, 32'h025A_5A5A);
    run_dir(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, -240, 0, 0);
    run_dir(32'hB000_0000, 1'b1, 1'b0, 1'b0,    4, 4, 0);
    run_dir(32'h7000_0000, 1'b0, 1'b0, 1'b0,   16, 0, 0);
    run_dir(32'h0800_0000, 1'b0, 1'b0, 1'b0,  -24, 0, 0);
    @(posedge clk);
    #1;

    // Back-to-back stream of ten words, tags 0..9.
    bus.out_ready = 1'b1;
    cnt   = 0;
    first = -1;
    last  = -1;
    for (int c = 0; c < 16; c++) begin
      drive_cycle(c < 10, (c < 10) ? $urandom : 32'h0, 8'(c), acc);
      if (c < 10) check("stream_acc", 64'(acc), 64'd1);
      if (bus.out_valid) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
    end
    bus.in_valid = 1'b0;
    check("stream_cnt", 64'(cnt), 64'd10);
    check("stream_span", 64'(last - first + 1), 64'd10);

    // Stall the consumer: the pipeline fills with three words and then holds.
    bus.out_ready = 1'b0;
    nacc = 0;
    tg   = 8'h40;
    p    = $urandom;
    for (int c = 0; c < 8; c++) begin
      drive_cycle(1'b1, p, tg, acc);
      if (acc) begin
        nacc++;
        tg++;
        p = $urandom;
      end
    end
    check("bp_acc", 64'(nacc), 64'd3);
    check("bp_iready", 64'(bus.in_ready), 64'd0);
    snap = observed();
    repeat (3) drive_cycle(1'b1, p, tg, acc);
    check("bp_hold", observed(), snap);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n0 = n_out;
    repeat (6) @(posedge clk);
    #1;
    check("bp_drain", 64'(n_out - n0), 64'd3);
    check("bp_empty", 64'(exp_q.size()), 64'd0);

    // Random traffic with random consumer stalls.
    nacc = 0;
    pend = 1'b0;
    v    = 1'b0;
    for (int c = 0; c < 8000 && nacc < 1000; c++) begin
      if (!pend) begin
        v = ($urandom_range(0, 3) != 0);
        p = rand_posit();
      end
      bus.out_ready = $urandom_range(0, 1) != 0;
      drive_cycle(v, p, 8'(nacc), acc);
      if (acc) begin
        nacc++;
        pend = 1'b0;
      end else begin
        pend = v;
      end
    end
    check("rnd_acc", 64'(nacc), 64'd1000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("rnd_drain", 64'(exp_q.size()), 64'd0);

    // Reset with three words in flight: they must vanish.
    for (int c = 0; c < 3; c++) drive_cycle(1'b1, $urandom, 8'(8'h80 + c), acc);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_ovalid", 64'(bus.out_valid), 64'd0);
    check("mid_iready", 64'(bus.in_ready), 64'd1);
    n0 = n_out;
    send_one(32'h4400_0000, 8'hAB, res, lat);
    check("mid_lat", 64'(lat), 64'd3);
    check("mid_res", res, pk(8'hAB, 1'b0, 1'b0, 1'b0, 1, 1, 0));
    repeat (4) @(posedge clk);
    #1;
    check("mid_count", 64'(n_out - n0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
